// File: rtl/pw_trigger_pkg.sv
// pw_trigger_pkg: state encoding and default geometry shared by
// pw_multi_trigger and its down-counter.
package pw_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam int DEF_NUM_PULSES  = 4;
    localparam int DEF_DELAY_WIDTH = 20;
    localparam int DEF_WIDTH_WIDTH = 17;
    localparam int DEF_COUNT_WIDTH = 16;
    localparam int DEF_NIDX        = $clog2(DEF_NUM_PULSES + 1);

    function automatic int nidx(input int num_pulses);
        return $clog2(num_pulses + 1);
    endfunction

endpackage

// File: rtl/pw_trigger_downcounter.sv
// pw_trigger_downcounter: loadable down-counter that parks at zero.
// One instance times both the delay and the width phase.
module pw_trigger_downcounter
#(
    parameter int pWIDTH = 20
) (
    input  logic              trigger_clk,
    input  logic              reset_n_i,
    input  logic              load,
    input  logic [pWIDTH-1:0] load_value,
    output logic              zero
);

    logic [pWIDTH-1:0] count;

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pw_multi_trigger.sv
// pw_multi_trigger: match-started sequence of up to pNUM_PULSES pulses.
// Define PW_TRIGGER_STATS_EN to build the sequence/missed statistics.
module pw_multi_trigger
    import pw_trigger_pkg::*;
#(
    parameter int pNUM_PULSES          = DEF_NUM_PULSES,
    parameter int pTRIGGER_DELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int pTRIGGER_WIDTH_WIDTH = DEF_WIDTH_WIDTH,
    parameter int pCOUNT_WIDTH         = DEF_COUNT_WIDTH,
    localparam int NIDX = $clog2(pNUM_PULSES + 1),
    localparam int DLW  = pNUM_PULSES * pTRIGGER_DELAY_WIDTH,
    localparam int WDW  = pNUM_PULSES * pTRIGGER_WIDTH_WIDTH
) (
    input  logic                    trigger_clk,
    input  logic                    reset_n_i,
    input  logic                    I_enable,
    input  logic                    I_match,
    input  logic [NIDX-1:0]         I_num_pulses,
    input  logic [DLW-1:0]          I_trigger_delay,
    input  logic [WDW-1:0]          I_trigger_width,
    output logic                    O_trigger,
    output logic                    O_busy,
    output logic [NIDX-1:0]         O_pulse_index,
    output logic [pCOUNT_WIDTH-1:0] O_seq_count,
    output logic [pCOUNT_WIDTH-1:0] O_missed_count
);

    localparam int NP = pNUM_PULSES;
    localparam int DW = pTRIGGER_DELAY_WIDTH;
    localparam int WW = pTRIGGER_WIDTH_WIDTH;
    localparam int CW = (DW > WW) ? DW : WW;

    state_t          state;
    logic [DLW-1:0]  delay_q;
    logic [WDW-1:0]  width_q;
    logic [NIDX-1:0] last_idx;
    logic            match_prev;
    logic            match_primed;

    logic            start;
    logic            last_pulse;
    logic [NIDX-1:0] next_idx;
    logic            cnt_load;
    logic [CW-1:0]   cnt_value;
    logic            cnt_zero;

    function automatic logic [NIDX-1:0] clamp_last(
        input logic [NIDX-1:0] n
    );
        if (n == '0) begin
            return '0;
        end
        if (n > NIDX'(NP)) begin
            return NIDX'(NP - 1);
        end
        return n - 1'b1;
    endfunction

    function automatic logic [CW-1:0] delay_at(
        input logic [DLW-1:0]  v,
        input logic [NIDX-1:0] k
    );
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            if (k == NIDX'(i)) begin
                r = CW'(v[i*DW +: DW]);
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] width_at(
        input logic [WDW-1:0]  v,
        input logic [NIDX-1:0] k
    );
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            if (k == NIDX'(i)) begin
                r = CW'(v[i*WW +: WW]);
            end
        end
        return r;
    endfunction

    // Counter runs value+1 cycles, so load max(v,1)-1.
    function automatic logic [CW-1:0] span(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_comb begin
        start      = I_match & ~match_prev & match_primed;
        last_pulse = (O_pulse_index == last_idx);
        next_idx   = O_pulse_index + 1'b1;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        unique case (state)
            ST_IDLE: begin
                if (start && I_enable) begin
                    cnt_load = 1'b1;
                    if (delay_at(I_trigger_delay, '0) == '0) begin
                        cnt_value = span(width_at(I_trigger_width, '0));
                    end else begin
                        cnt_value = span(delay_at(I_trigger_delay, '0));
                    end
                end
            end
            ST_DELAY: begin
                if (I_enable && cnt_zero) begin
                    cnt_load  = 1'b1;
                    cnt_value = span(width_at(width_q, O_pulse_index));
                end
            end
            ST_PULSE: begin
                if (I_enable && cnt_zero && !last_pulse) begin
                    cnt_load  = 1'b1;
                    cnt_value = span(delay_at(delay_q, next_idx));
                end
            end
            default: ;
        endcase
    end

    pw_trigger_downcounter #(
        .pWIDTH (CW)
    ) u_counter (
        .trigger_clk (trigger_clk),
        .reset_n_i   (reset_n_i),
        .load        (cnt_load),
        .load_value  (cnt_value),
        .zero        (cnt_zero)
    );

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= ST_IDLE;
            O_trigger     <= 1'b0;
            O_busy        <= 1'b0;
            O_pulse_index <= '0;
            delay_q       <= '0;
            width_q       <= '0;
            last_idx      <= '0;
            match_prev    <= 1'b0;
            match_primed  <= 1'b0;
        end else begin
            match_prev <= I_match;
            if (!I_match) begin
                match_primed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start && I_enable) begin
                        delay_q  <= I_trigger_delay;
                        width_q  <= I_trigger_width;
                        last_idx <= clamp_last(I_num_pulses);
                        O_busy   <= 1'b1;
                        if (delay_at(I_trigger_delay, '0) == '0) begin
                            state     <= ST_PULSE;
                            O_trigger <= 1'b1;
                        end else begin
                            state <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!I_enable) begin
                        state         <= ST_IDLE;
                        O_trigger     <= 1'b0;
                        O_busy        <= 1'b0;
                        O_pulse_index <= '0;
                    end else if (cnt_zero) begin
                        state     <= ST_PULSE;
                        O_trigger <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (!I_enable) begin
                        state         <= ST_IDLE;
                        O_trigger     <= 1'b0;
                        O_busy        <= 1'b0;
                        O_pulse_index <= '0;
                    end else if (cnt_zero) begin
                        O_trigger <= 1'b0;
                        if (last_pulse) begin
                            state         <= ST_IDLE;
                            O_busy        <= 1'b0;
                            O_pulse_index <= '0;
                        end else begin
                            state         <= ST_DELAY;
                            O_pulse_index <= next_idx;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    O_trigger <= 1'b0;
                    O_busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PW_TRIGGER_STATS_EN
    logic seq_done;
    logic missed;

    assign seq_done = (state == ST_PULSE) && I_enable
                    && cnt_zero && last_pulse;
    assign missed   = start && (state != ST_IDLE);

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            O_seq_count    <= '0;
            O_missed_count <= '0;
        end else begin
            if (seq_done && (O_seq_count != '1)) begin
                O_seq_count <= O_seq_count + 1'b1;
            end
            if (missed && (O_missed_count != '1)) begin
                O_missed_count <= O_missed_count + 1'b1;
            end
        end
    end
`else
    assign O_seq_count    = '0;
    assign O_missed_count = '0;
`endif

endmodule

// File: tb/tb_pw_multi_trigger.sv
// tb_pw_multi_trigger: directed and random stimulus against a
// schedule-based reference model of the pulse sequence.
module tb_pw_multi_trigger;

    localparam int NP   = 4;
    localparam int DW   = 5;
    localparam int WW   = 4;
    localparam int CNTW = 3;
    localparam int NIDX = $clog2(NP + 1);
    localparam int SATV = (1 << CNTW) - 1;

    logic                trigger_clk = 1'b0;
    logic                reset_n_i = 1'b1;
    logic                I_enable = 1'b0;
    logic                I_match = 1'b0;
    logic [NIDX-1:0]     I_num_pulses = '0;
    logic [NP*DW-1:0]    I_trigger_delay = '0;
    logic [NP*WW-1:0]    I_trigger_width = '0;
    logic                O_trigger;
    logic                O_busy;
    logic [NIDX-1:0]     O_pulse_index;
    logic [CNTW-1:0]     O_seq_count;
    logic [CNTW-1:0]     O_missed_count;

    pw_multi_trigger #(
        .pNUM_PULSES          (NP),
        .pTRIGGER_DELAY_WIDTH (DW),
        .pTRIGGER_WIDTH_WIDTH (WW),
        .pCOUNT_WIDTH         (CNTW)
    ) dut (
        .trigger_clk     (trigger_clk),
        .reset_n_i       (reset_n_i),
        .I_enable        (I_enable),
        .I_match         (I_match),
        .I_num_pulses    (I_num_pulses),
        .I_trigger_delay (I_trigger_delay),
        .I_trigger_width (I_trigger_width),
        .O_trigger       (O_trigger),
        .O_busy          (O_busy),
        .O_pulse_index   (O_pulse_index),
        .O_seq_count     (O_seq_count),
        .O_missed_count  (O_missed_count)
    );

    always #5 trigger_clk = ~trigger_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: one accepted sequence = start cycle plus latched config.
    bit m_act;
    int m_n;
    int m_np;
    int m_d[NP];
    int m_w[NP];
    bit m_prev;
    bit m_primed;
    int m_seq;
    int m_miss;

    bit n_trig, n_busy;
    int n_idx;
    bit e_trig, e_busy;
    int e_idx, e_seq, e_miss;
    bit chk_en = 1'b0;

    bit rec_on = 1'b0;
    int rec_base = 0;
    logic [31:0] dut_trig_h, dut_busy_h, exp_trig_h;

    function automatic void chk(input string nm, input longint act,
                                input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endfunction

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int sat(input int v);
        return (v > SATV) ? SATV : v;
    endfunction

    // Expected outputs at cycle t for the latched sequence.
    function automatic void eval(input int t, output bit trig,
                                 output bit busy, output int idx,
                                 output int last_hi);
        int pos, rise, fall;
        bit found;
        trig = 0;
        idx = 0;
        found = 0;
        pos = m_n + 1;
        for (int k = 0; k < m_np; k++) begin
            rise = pos + ((k == 0) ? m_d[0] : max1(m_d[k]));
            fall = rise + max1(m_w[k]);
            if (!found && t < fall) begin
                found = 1;
                idx = k;
                trig = (t >= rise);
            end
            pos = fall;
        end
        last_hi = pos - 1;
        busy = (t >= m_n + 1) && (t <= last_hi);
        if (!busy) begin
            trig = 0;
            idx = 0;
        end
    endfunction

    task automatic model_step();
        bit tr, bz, edge_m;
        int ix, lh;
        edge_m = I_match && !m_prev && m_primed;
        bz = 0;
        if (m_act) eval(cyc, tr, bz, ix, lh);
        if (bz) begin
            if (edge_m) m_miss = sat(m_miss + 1);
            if (!I_enable) begin
                m_act = 0;
            end else if (cyc == lh) begin
                m_act = 0;
                m_seq = sat(m_seq + 1);
            end
        end else begin
            m_act = 0;
            if (edge_m && I_enable) begin
                m_act = 1;
                m_n = cyc;
                m_np = (I_num_pulses == 0) ? 1 :
                       (int'(I_num_pulses) > NP) ? NP : int'(I_num_pulses);
                for (int k = 0; k < NP; k++) begin
                    m_d[k] = int'(I_trigger_delay[k*DW +: DW]);
                    m_w[k] = int'(I_trigger_width[k*WW +: WW]);
                end
            end
        end
        m_prev = I_match;
        if (!I_match) m_primed = 1;
        n_trig = 0;
        n_busy = 0;
        n_idx = 0;
        if (m_act) eval(cyc + 1, n_trig, n_busy, n_idx, lh);
    endtask

    task automatic step();
        model_step();
        @(posedge trigger_clk);
        #1;
        cyc++;
        e_trig = n_trig;
        e_busy = n_busy;
        e_idx = n_idx;
`ifdef PW_TRIGGER_STATS_EN
        e_seq = m_seq;
        e_miss = m_miss;
`else
        e_seq = 0;
        e_miss = 0;
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge trigger_clk) begin
        if (chk_en) begin
            chk("trigger", O_trigger, e_trig);
            chk("busy", O_busy, e_busy);
            chk("pulse_index", O_pulse_index, e_idx);
            chk("seq_count", O_seq_count, e_seq);
            chk("missed_count", O_missed_count, e_miss);
        end
        if (rec_on && cyc - rec_base >= 0 && cyc - rec_base < 32) begin
            dut_trig_h[cyc - rec_base] = O_trigger;
            dut_busy_h[cyc - rec_base] = O_busy;
            exp_trig_h[cyc - rec_base] = e_trig;
        end
    end

    task automatic start_rec();
        dut_trig_h = '0;
        dut_busy_h = '0;
        exp_trig_h = '0;
        rec_base = cyc;
        rec_on = 1;
    endtask

    task automatic do_reset();
        chk_en = 0;
        reset_n_i = 0;
        #1;
        chk("rst_trigger", O_trigger, 0);
        chk("rst_busy", O_busy, 0);
        chk("rst_index", O_pulse_index, 0);
        chk("rst_seq", O_seq_count, 0);
        chk("rst_missed", O_missed_count, 0);
        m_act = 0;
        m_prev = 0;
        m_primed = 0;
        m_seq = 0;
        m_miss = 0;
        e_trig = 0;
        e_busy = 0;
        e_idx = 0;
        e_seq = 0;
        e_miss = 0;
        @(posedge trigger_clk);
        #1;
        cyc++;
        reset_n_i = 1;
        chk_en = 1;
    endtask

    task automatic set_pulse(input int k, input int d, input int w);
        I_trigger_delay[k*DW +: DW] = DW'(d);
        I_trigger_width[k*WW +: WW] = WW'(w);
    endtask

    task automatic rand_cfg();
        I_num_pulses = NIDX'($urandom_range(0, 7));
        for (int k = 0; k < NP; k++) begin
            I_trigger_delay[k*DW +: DW] = ($urandom_range(0, 15) == 0)
                ? {DW{1'b1}} : DW'($urandom_range(0, 4));
            I_trigger_width[k*WW +: WW] = ($urandom_range(0, 15) == 0)
                ? {WW{1'b1}} : WW'($urandom_range(0, 3));
        end
    endtask

    initial begin
        int base;
        bit found;
        logic [11:0] pat;
        #2;
        do_reset();
        I_enable = 1;
        I_match = 0;

        // Single pulse, delay 3 width 2.
        I_num_pulses = 1;
        set_pulse(0, 3, 2);
        run(2);
        start_rec();
        I_match = 1;
        run(1);
        I_match = 0;
        run(11);
        rec_on = 0;
        chk("s1_trig_hist", dut_trig_h[9:0], 10'h030);
        chk("s1_busy_hist", dut_busy_h[9:0], 10'h03E);
        chk("s1_model_hist", exp_trig_h[9:0], 10'h030);

        // Two pulses, delays {3,2}, widths {2,1}.
        I_num_pulses = 2;
        set_pulse(1, 2, 1);
        start_rec();
        I_match = 1;
        run(1);
        I_match = 0;
        run(13);
        rec_on = 0;
        chk("s2_trig_hist", dut_trig_h[11:0], 12'h130);
        chk("s2_busy_hist", dut_busy_h[11:0], 12'h1FE);
        chk("s2_model_hist", exp_trig_h[11:0], 12'h130);

        // Zero delay/width with match held high.
        I_num_pulses = 0;
        set_pulse(0, 0, 0);
        base = m_seq;
        start_rec();
        I_match = 1;
        run(20);
        I_match = 0;
        run(4);
        rec_on = 0;
        chk("s3_trig_hist", dut_trig_h[23:0], 24'h000002);
        chk("s3_busy_hist", dut_busy_h[23:0], 24'h000002);
        chk("s3_model_seqs", m_seq - base, 1);

        // Enable dropped in cycle 5 of a long sequence.
        I_num_pulses = 4;
        for (int k = 0; k < NP; k++) set_pulse(k, 10, 10);
        base = m_seq;
        start_rec();
        I_match = 1;
        run(1);
        I_match = 0;
        run(4);
        I_enable = 0;
        run(1);
        I_enable = 1;
        run(6);
        rec_on = 0;
        chk("s4_trig_hist", dut_trig_h[10:0], 11'h000);
        chk("s4_busy_hist", dut_busy_h[10:0], 11'h03E);
        chk("s4_model_seqs", m_seq - base, 0);

        // Three extra edges during one sequence.
        do_reset();
        I_num_pulses = 1;
        set_pulse(0, 5, 5);
        run(2);
        pat = 12'h055;
        for (int i = 0; i < 12; i++) begin
            I_match = pat[i];
            run(1);
        end
        run(2);
`ifdef PW_TRIGGER_STATS_EN
        chk("s5_missed", O_missed_count, 3);
        chk("s5_seq", O_seq_count, 1);
`else
        chk("s5_missed_tied", O_missed_count, 0);
        chk("s5_seq_tied", O_seq_count, 0);
`endif

        // Drive both counters into saturation.
        set_pulse(0, 1, 1);
        for (int i = 0; i < 48; i++) begin
            I_match = ~I_match;
            run(1);
        end
        I_match = 0;
        run(3);
`ifdef PW_TRIGGER_STATS_EN
        chk("sat_missed", O_missed_count, SATV);
        chk("sat_seq", O_seq_count, SATV);
`else
        chk("sat_missed_tied", O_missed_count, 0);
        chk("sat_seq_tied", O_seq_count, 0);
`endif

        // Random traffic, config changing mid-sequence.
        for (int i = 0; i < 4000; i++) begin
            I_match = ($urandom_range(0, 99) < 40);
            I_enable = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 7) == 0) rand_cfg();
            run(1);
        end

        // Asynchronous reset while a pulse is high.
        I_enable = 1;
        I_match = 0;
        I_num_pulses = 2;
        set_pulse(0, 1, 6);
        set_pulse(1, 1, 6);
        run(300);
        I_match = 1;
        run(1);
        I_match = 0;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (!found) begin
                run(1);
                if (O_trigger) found = 1;
            end
        end
        chk("wait_pulse_high", found, 1);
        I_match = 1;
        do_reset();

        // Match high across reset release must not start.
        run(3);
        chk("no_start_held_match", O_busy, 0);
        I_match = 0;
        run(1);
        I_match = 1;
        run(1);
        chk("start_after_low", O_busy, 1);
        I_match = 0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
